// File: rtl/ddc_frame_buffer.sv
// ddc_frame_buffer
// Captures DDC frames (PPS count, sub-PPS time stamp, NUM_CH channel words)
// into a DEPTH-row buffer and exposes the head frame through an indexed,
// registered read port. The HPS pops the head frame by toggling
// hps_pop_toggle. Frames arriving while the buffer is full are dropped
// and counted in a saturating 16-bit counter.
//
// Optional feature: define DDC_FRAME_BUFFER_SEQ_EN to store a 16-bit frame
// sequence number as word NUM_CH+2 of every row. The sequence counter
// advances on every enabled strobe, including dropped ones, so software can
// detect drops as gaps.
//
// Handshake: a capture is accepted when ch_valid & capture_en & !full, with
// full judged on the registered fill level before any same-cycle pop. A pop
// is any level change of hps_pop_toggle and only acts when a frame is held.
module ddc_frame_buffer #(
   parameter int NUM_CH = 32,
   parameter int DATA_W = 32,
   parameter int TS_W   = 26,
   parameter int DEPTH  = 16,
   parameter int SEL_W  = 7
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset,
   input  logic                       capture_en,
   input  logic                       ch_valid,
   input  logic [NUM_CH*DATA_W-1:0]   ch_data,
   input  logic [31:0]                pps_count,
   input  logic [TS_W-1:0]            time_in,
   input  logic [SEL_W-1:0]           hps_rd_sel,
   input  logic                       hps_pop_toggle,
   output logic [DATA_W-1:0]          hps_rd_data,
   output logic                       frame_avail,
   output logic [$clog2(DEPTH):0]     fill_level,
   output logic [15:0]                overflow_count
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;
`ifdef DDC_FRAME_BUFFER_SEQ_EN
   localparam int ROW_WORDS = NUM_CH + 3;
`else
   localparam int ROW_WORDS = NUM_CH + 2;
`endif
   localparam int ROW_W = ROW_WORDS * DATA_W;

   // Storage: one packed row per frame; contents are not reset.
   logic [ROW_W-1:0]  mem [DEPTH];

   // Free-running pointers with an extra MSB; only the low bits address rows.
   logic [PTR_W:0]    wr_ptr;
   logic [PTR_W:0]    rd_ptr;
   logic [FILL_W-1:0] fill_next;
   logic              toggle_q;
   logic              pop_evt;
   logic              full;
   logic              strobe;
   logic              accept;
   logic              drop;
   logic              pop;
   logic [ROW_W-1:0]  new_row;
   logic [ROW_W-1:0]  head_row;
   logic [DATA_W-1:0] sel_word;

`ifdef DDC_FRAME_BUFFER_SEQ_EN
   logic [15:0]       seq_cnt;
`endif

   // Capture and pop qualification; full is judged before any same-cycle pop.
   always_comb begin
      strobe  = ch_valid & capture_en;
      full    = (fill_level == FILL_W'(DEPTH));
      accept  = strobe & ~full;
      drop    = strobe & full;
      pop_evt = hps_pop_toggle ^ toggle_q;
      pop     = pop_evt & (fill_level != '0);
   end

   // Next fill level: a simultaneous accept and pop leaves it unchanged.
   always_comb begin
      fill_next = fill_level;
      if (accept && !pop) begin
         fill_next = fill_level + FILL_W'(1);
      end else if (pop && !accept) begin
         fill_next = fill_level - FILL_W'(1);
      end
   end

   // Assemble the row image written on an accepted capture.
   always_comb begin
      new_row = '0;
      new_row[0 +: DATA_W]                 = DATA_W'(pps_count);
      new_row[DATA_W +: DATA_W]            = DATA_W'(time_in);
      new_row[2*DATA_W +: NUM_CH*DATA_W]   = ch_data;
`ifdef DDC_FRAME_BUFFER_SEQ_EN
      new_row[(NUM_CH+2)*DATA_W +: DATA_W] = DATA_W'(seq_cnt);
`endif
   end

   // Select the requested word of the head row; out-of-range indices give 0.
   always_comb begin
      sel_word = '0;
      for (int w = 0; w < ROW_WORDS; w++) begin
         if (int'(hps_rd_sel) == w) begin
            sel_word = head_row[w*DATA_W +: DATA_W];
         end
      end
   end

   assign head_row = mem[rd_ptr[PTR_W-1:0]];

   // Row write: the whole frame lands at wr_ptr in a single cycle.
   always_ff @(posedge clk_clk) begin
      if (accept && !reset_reset) begin
         mem[wr_ptr[PTR_W-1:0]] <= new_row;
      end
   end

   // Toggle history; reset loads the live level so release causes no pop.
   always_ff @(posedge clk_clk) begin
      toggle_q <= hps_pop_toggle;
   end

   // Pointers, fill level and availability flag.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         frame_avail <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         fill_level  <= fill_next;
         frame_avail <= (fill_next != '0);
      end
   end

   // Saturating count of frames dropped because the buffer was full.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         overflow_count <= '0;
      end else if (drop && (overflow_count != 16'hFFFF)) begin
         overflow_count <= overflow_count + 16'd1;
      end
   end

   // Registered read port: one cycle behind the select and the head pointer.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         hps_rd_data <= '0;
      end else if (fill_level != '0) begin
         hps_rd_data <= sel_word;
      end else begin
         hps_rd_data <= '0;
      end
   end

`ifdef DDC_FRAME_BUFFER_SEQ_EN
   // Frame sequence number: advances on every enabled strobe, wraps freely.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         seq_cnt <= '0;
      end else if (strobe) begin
         seq_cnt <= seq_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ddc_frame_buffer.sv
// Bench for ddc_frame_buffer: a constant vector table for basic capture,
// read and pop, hand-written corner sequences, and randomized traffic
// checked against a queue-of-frames reference model.
module tb_ddc_frame_buffer;

   localparam int NUM_CH = 32;
   localparam int DW     = 32;
   localparam int TS_W   = 26;
   localparam int DEPTH  = 16;
   localparam int SEL_W  = 7;
   localparam int FW     = $clog2(DEPTH) + 1;
`ifdef DDC_FRAME_BUFFER_SEQ_EN
   localparam int MAX_SEL = NUM_CH + 2;
`else
   localparam int MAX_SEL = NUM_CH + 1;
`endif
   localparam int ROWB = (NUM_CH + 3) * DW;

   // ---------------- clock / reset / DUT ----------------
   logic                   clk_clk = 1'b0;
   logic                   reset_reset = 1'b1;
   logic                   capture_en = 1'b0;
   logic                   ch_valid = 1'b0;
   logic [NUM_CH*DW-1:0]   ch_data = '0;
   logic [31:0]            pps_count = '0;
   logic [TS_W-1:0]        time_in = '0;
   logic [SEL_W-1:0]       hps_rd_sel = '0;
   logic                   hps_pop_toggle = 1'b0;
   logic [DW-1:0]          hps_rd_data;
   logic                   frame_avail;
   logic [FW-1:0]          fill_level;
   logic [15:0]            overflow_count;

   always #5 clk_clk = ~clk_clk;

   ddc_frame_buffer #(
      .NUM_CH(NUM_CH), .DATA_W(DW), .TS_W(TS_W), .DEPTH(DEPTH), .SEL_W(SEL_W)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .capture_en     (capture_en),
      .ch_valid       (ch_valid),
      .ch_data        (ch_data),
      .pps_count      (pps_count),
      .time_in        (time_in),
      .hps_rd_sel     (hps_rd_sel),
      .hps_pop_toggle (hps_pop_toggle),
      .hps_rd_data    (hps_rd_data),
      .frame_avail    (frame_avail),
      .fill_level     (fill_level),
      .overflow_count (overflow_count)
   );

   // ---------------- scoreboard / reference model ----------------
   int checks = 0;
   int errors = 0;

   logic [ROWB-1:0] mq[$];     // frames held, head at index 0
   logic [DW-1:0]   exp_q[$];  // expected hps_rd_data after the coming edge
   int              m_ovf = 0;
   int              m_seq = 0;
   logic            m_tog = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Apply the frame-buffer rules to the inputs present before the edge.
   task automatic model_step();
      logic [ROWB-1:0] row;
      bit              full;
      bit              do_pop;
      int              s;
      exp_q.delete();
      if (reset_reset) begin
         mq.delete();
         m_ovf = 0;
         m_seq = 0;
         m_tog = hps_pop_toggle;
         exp_q.push_back('0);
      end else begin
         s = int'(hps_rd_sel);
         if (mq.size() != 0 && s <= MAX_SEL) exp_q.push_back(mq[0][s*DW +: DW]);
         else exp_q.push_back('0);
         full   = (mq.size() == DEPTH);
         do_pop = (hps_pop_toggle != m_tog) && (mq.size() > 0);
         m_tog  = hps_pop_toggle;
         if (do_pop) void'(mq.pop_front());
         if (capture_en && ch_valid) begin
            if (full) begin
               if (m_ovf < 65535) m_ovf++;
            end else begin
               row = '0;
               row[0 +: DW]               = pps_count;
               row[DW +: DW]              = DW'(time_in);
               row[2*DW +: NUM_CH*DW]     = ch_data;
`ifdef DDC_FRAME_BUFFER_SEQ_EN
               row[(NUM_CH+2)*DW +: DW]   = DW'(m_seq[15:0]);
`endif
               mq.push_back(row);
            end
            m_seq = (m_seq + 1) % 65536;
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".fill"}, 32'(fill_level), 32'(mq.size()));
      chk({tag, ".avail"}, 32'(frame_avail), 32'(mq.size() != 0));
      chk({tag, ".ovf"}, 32'(overflow_count), 32'(m_ovf));
      chk({tag, ".data"}, hps_rd_data, exp_q[0]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic rand_frame(input logic [31:0] pps);
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DW +: DW] = $urandom;
      pps_count = pps;
      time_in   = TS_W'($urandom);
   endtask

   task automatic do_reset();
      reset_reset = 1'b1;
      ch_valid    = 1'b0;
      tick();
      reset_reset = 1'b0;
      capture_en  = 1'b1;
      tick();
   endtask

   task automatic strobe_checked(input logic [31:0] pps, input string tag);
      rand_frame(pps);
      ch_valid = 1'b1;
      tick();
      check_model(tag);
      ch_valid = 1'b0;
   endtask

   task automatic pop_checked(input string tag);
      hps_pop_toggle = ~hps_pop_toggle;
      tick();
      check_model(tag);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        en;
      logic        vld;
      logic        tog;
      logic [31:0] pps;
      logic [6:0]  sel;
      int          fill;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[13];

   initial begin
      int base_ovf;

      vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'd5, 7'd0,  1, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd0,  1, 32'h5};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd1,  1, 32'h123};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd2,  1, 32'h1000};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd33, 1, 32'h101F};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd40, 1, 32'h0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd34, 1, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd0, 7'd0,  0, 32'h5};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'd0, 7'd0,  0, 32'h0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd0,  0, 32'h0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd9, 7'd0,  0, 32'h0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 32'd7, 7'd0,  1, 32'h0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 32'd0, 7'd0,  1, 32'h7};

      // Reset state
      tick();
      tick();
      chk("reset.fill", 32'(fill_level), 32'd0);
      chk("reset.avail", 32'(frame_avail), 32'd0);
      chk("reset.ovf", 32'(overflow_count), 32'd0);
      chk("reset.data", hps_rd_data, 32'd0);
      reset_reset = 1'b0;

      // Table: capture, indexed reads, pop and empty pop
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DW +: DW] = 32'h1000 + k;
      time_in = 26'h123;
      for (int i = 0; i < 13; i++) begin
         capture_en     = vecs[i].en;
         ch_valid       = vecs[i].vld;
         hps_pop_toggle = vecs[i].tog;
         pps_count      = vecs[i].pps;
         hps_rd_sel     = vecs[i].sel;
         tick();
         chk($sformatf("vec%0d.fill", i), 32'(fill_level), 32'(vecs[i].fill));
         chk($sformatf("vec%0d.avail", i), 32'(frame_avail), 32'(vecs[i].fill != 0));
         chk($sformatf("vec%0d.data", i), hps_rd_data, vecs[i].data);
         chk($sformatf("vec%0d.ovf", i), 32'(overflow_count), 32'd0);
      end
      ch_valid = 1'b0;

      // Overflow: 20 strobes, then 16 ordered pops
      hps_rd_sel = '0;
      do_reset();
      for (int i = 0; i < 20; i++) strobe_checked(32'(i), "ovf.fill");
      chk("ovf.fill16", 32'(fill_level), 32'd16);
      chk("ovf.count4", 32'(overflow_count), 32'd4);
      for (int i = 0; i < 16; i++) begin
         pop_checked("ovf.pop");
         chk($sformatf("ovf.order%0d", i), hps_rd_data, 32'(i));
      end
      tick();
      check_model("ovf.empty");
      chk("ovf.empty.data", hps_rd_data, 32'd0);

      // Full plus pop plus valid: pop acts, frame still dropped
      do_reset();
      for (int i = 0; i < 16; i++) strobe_checked(32'(100 + i), "sim.fill");
      base_ovf = int'(overflow_count);
      rand_frame(32'd999);
      ch_valid = 1'b1;
      hps_pop_toggle = ~hps_pop_toggle;
      tick();
      ch_valid = 1'b0;
      check_model("sim.full");
      chk("sim.full.fill15", 32'(fill_level), 32'd15);
      chk("sim.full.ovf", 32'(overflow_count), 32'(base_ovf + 1));
      for (int i = 0; i < 12; i++) pop_checked("sim.drain");
      chk("sim.fill3", 32'(fill_level), 32'd3);
      // Steady state at three frames, wrapping the pointers
      for (int i = 0; i < 40; i++) begin
         rand_frame(32'(200 + i));
         ch_valid = 1'b1;
         hps_pop_toggle = ~hps_pop_toggle;
         hps_rd_sel = 7'($urandom_range(0, 35));
         tick();
         check_model("sim.steady");
      end
      ch_valid = 1'b0;
      chk("sim.steady.fill3", 32'(fill_level), 32'd3);

      // Reset mid-stream with the toggle raised at the same time
      hps_rd_sel = '0;
      do_reset();
      for (int i = 0; i < 5; i++) strobe_checked(32'(300 + i), "rst.fill");
      reset_reset = 1'b1;
      hps_pop_toggle = ~hps_pop_toggle;
      tick();
      chk("rst.fill", 32'(fill_level), 32'd0);
      chk("rst.avail", 32'(frame_avail), 32'd0);
      chk("rst.ovf", 32'(overflow_count), 32'd0);
      chk("rst.data", hps_rd_data, 32'd0);
      reset_reset = 1'b0;
      tick();
      check_model("rst.release");
      strobe_checked(32'hABC, "rst.capture");
      tick();
      check_model("rst.read");
      chk("rst.head", hps_rd_data, 32'hABC);
      chk("rst.one", 32'(fill_level), 32'd1);

      // Randomized traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         reset_reset = ($urandom_range(0, 99) == 0);
         capture_en  = ($urandom_range(0, 9) != 0);
         ch_valid    = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 99) < 35) hps_pop_toggle = ~hps_pop_toggle;
         hps_rd_sel  = 7'($urandom_range(0, 40));
         rand_frame($urandom);
         tick();
         check_model("rand");
      end
      reset_reset = 1'b0;
      ch_valid    = 1'b0;
      capture_en  = 1'b1;

`ifdef DDC_FRAME_BUFFER_SEQ_EN
      // Sequence word: 18 strobes, disabled strobes, then drain
      hps_rd_sel = 7'(NUM_CH + 2);
      do_reset();
      for (int i = 0; i < 18; i++) strobe_checked($urandom, "seq.fill");
      capture_en = 1'b0;
      for (int i = 0; i < 3; i++) strobe_checked($urandom, "seq.off");
      capture_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pop_checked("seq.pop");
         chk($sformatf("seq.word%0d", i), hps_rd_data, 32'(i));
      end
      strobe_checked($urandom, "seq.next");
      tick();
      check_model("seq.next.read");
      chk("seq.pending18", hps_rd_data, 32'd18);
`endif

      // Saturation: keep the buffer full and drop more than 65535 frames
      hps_rd_sel = '0;
      do_reset();
      for (int i = 0; i < 16; i++) strobe_checked(32'(i), "sat.fill");
      ch_valid = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         pps_count = 32'(i);
         tick();
         check_model("sat");
      end
      ch_valid = 1'b0;
      chk("sat.ovf", 32'(overflow_count), 32'hFFFF);
      chk("sat.fill", 32'(fill_level), 32'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
